// File: rtl/sevenseg_scan_driver_if.sv
// sevenseg_scan_driver_if: load/ack value handshake plus scanned display outputs
interface sevenseg_scan_driver_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic                    load;
  logic                    load_ack;
  logic                    frame_done;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  modport master (output value, dp_mask, blank_lz, load, input load_ack, frame_done, an, seg, dp);
  modport slave (input value, dp_mask, blank_lz, load, output load_ack, frame_done, an, seg, dp);
endinterface

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: frame-synchronous latched hex value scanned onto a common-anode 7-segment display
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  sevenseg_scan_driver_if.slave   bus
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int W  = 4 * NUM_DIGITS;
  localparam logic [16*7-1:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  logic [DW-1:0]         r_div;
  logic [IW-1:0]         r_idx;
  logic [W-1:0]          r_pend, r_disp;
  logic [NUM_DIGITS-1:0] r_pend_dp, r_disp_dp, r_an;
  logic                  r_pend_v, r_ack, r_fd, r_dp;
  logic [6:0]            r_seg;
  logic                  w_div_end, w_idx_end, w_bound, w_off;
  logic [NUM_DIGITS-1:0] w_zhi;
  logic [3:0]            w_nib;
  genvar k;
  for (k = 0; k < NUM_DIGITS; k++) begin : g_zhi
    assign w_zhi[k] = r_disp[W-1:4*k] == '0;
  end
  assign w_div_end = r_div == DW'(REFRESH_DIV - 1);
  assign w_idx_end = r_idx == IW'(NUM_DIGITS - 1);
  assign w_bound   = w_div_end && w_idx_end;
  assign w_nib     = r_disp[4*r_idx +: 4];
  // slot start is a dark gap against ghosting; blanked leading zeros stay dark too
  assign w_off     = r_div == '0 || (bus.blank_lz && r_idx != '0 && w_zhi[r_idx]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_idx     <= '0;
      r_pend    <= '0;
      r_pend_dp <= '0;
      r_pend_v  <= 1'b0;
      r_disp    <= '0;
      r_disp_dp <= '0;
      r_an      <= '1;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
      r_ack     <= 1'b0;
      r_fd      <= 1'b0;
    end else begin
      r_div <= w_div_end ? '0 : r_div + 1'b1;
      if (w_div_end) r_idx <= w_idx_end ? '0 : r_idx + 1'b1;
      r_an  <= w_off ? '1 : ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_off ? 7'h7F : SEG_LUT[7*w_nib +: 7];
      r_dp  <= w_off | ~r_disp_dp[r_idx];
      r_fd  <= w_bound;
      r_ack <= w_bound && r_pend_v;
      if (w_bound && r_pend_v) begin
        r_disp    <= r_pend;
        r_disp_dp <= r_pend_dp;
      end
      if (bus.load) begin
        r_pend    <= bus.value;
        r_pend_dp <= bus.dp_mask;
        r_pend_v  <= 1'b1;
      end else if (w_bound) r_pend_v <= 1'b0;
    end
  end
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.load_ack   = r_ack;
  assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: cycle-count reference model plus directed display scenarios
module tb_sevenseg_scan_driver;
  localparam int N = 4;
  localparam int R = 4;
  logic clk, rst_n;
  int checks = 0, fails = 0;
  sevenseg_scan_driver_if #(.NUM_DIGITS(N)) bus();
  sevenseg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int m_n;
  logic [15:0] m_pend, m_disp;
  logic [3:0] m_pend_dp, m_disp_dp;
  logic m_pend_v;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic e_dp, e_ack, e_fd, e_vis, e_gap;
  int p, d;
  logic [15:0] hi;
  logic bnd, off;
  logic [3:0] an_v;
  // digit position and slot phase follow directly from edges counted since reset
  always_comb begin
    p = m_n % R;
    d = (m_n / R) % N;
    hi = m_disp >> (4 * d);
    bnd = (p == R - 1) && (d == N - 1);
    off = (p == 0) || (bus.blank_lz && d > 0 && hi == 16'h0);
    an_v = 4'hF;
    if (!off) an_v[d] = 1'b0;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_pend <= '0; m_pend_dp <= '0; m_pend_v <= 1'b0; m_disp <= '0; m_disp_dp <= '0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_ack <= 1'b0; e_fd <= 1'b0; e_vis <= 1'b0; e_gap <= 1'b1;
    end else begin
      e_an  <= an_v;
      e_seg <= off ? 7'h7F : lut[hi[3:0]];
      e_dp  <= off | ~m_disp_dp[d];
      e_vis <= !off;
      e_gap <= p == 0;
      e_fd  <= bnd;
      e_ack <= bnd && m_pend_v;
      if (bnd && m_pend_v) begin m_disp <= m_pend; m_disp_dp <= m_pend_dp; end
      if (bus.load) begin m_pend <= bus.value; m_pend_dp <= bus.dp_mask; m_pend_v <= 1'b1; end
      else if (bnd) m_pend_v <= 1'b0;
      m_n <= m_n + 1;
    end
  end
  logic [6:0] seen_seg [N];
  logic seen_dp [N];
  logic active [N];
  int vis_cnt [N];
  int ack_cnt = 0, first_fd_n = -1, last_fd_n = -1, last_period = -1;
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic clear_seen();
    for (int i = 0; i < N; i++) begin seen_seg[i] = 7'h7F; seen_dp[i] = 1'b1; active[i] = 1'b0; vis_cnt[i] = 0; end
  endtask
  task automatic cmp_cycle();
    chk("an", bus.an, e_an);
    chk("frame_done", bus.frame_done, e_fd);
    chk("load_ack", bus.load_ack, e_ack);
    if (e_vis || e_gap) chk("seg", bus.seg, e_seg);
    if (e_vis) chk("dp", bus.dp, e_dp);
    if (!rst_n) begin first_fd_n = -1; last_fd_n = -1; end
    else begin
      for (int i = 0; i < N; i++)
        if (!bus.an[i]) begin seen_seg[i] = bus.seg; seen_dp[i] = bus.dp; active[i] = 1'b1; vis_cnt[i]++; end
      if (bus.load_ack) ack_cnt++;
      if (bus.frame_done) begin
        if (last_fd_n >= 0) last_period = m_n - last_fd_n;
        if (first_fd_n < 0) first_fd_n = m_n;
        last_fd_n = m_n;
      end
    end
  endtask
  task automatic step(int n);
    repeat (n) begin @(negedge clk); cmp_cycle(); end
  endtask
  task automatic wait_fd();
    int k = 0;
    do begin step(1); k++; end while (!bus.frame_done && k < 100);
    chk("frame_done_timeout", bus.frame_done, 1);
  endtask
  task automatic pulse(logic [15:0] v, logic [3:0] m);
    bus.value = v; bus.dp_mask = m; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask
  int base;
  initial begin
    bus.value = '0; bus.dp_mask = '0; bus.blank_lz = 1'b0; bus.load = 1'b0;
    rst_n = 1'b0;
    clear_seen();
    step(3);
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_dp", bus.dp, 1);
    chk("rst_ack", bus.load_ack, 0);
    rst_n = 1'b1;
    wait_fd();
    chk("first_fd_cycle", first_fd_n, 16);
    clear_seen();
    wait_fd();
    chk("fd_period", last_period, 16);
    for (int i = 0; i < N; i++) chk("slot_visible_cycles", vis_cnt[i], R - 1);
    step(5);
    pulse(16'h1234, 4'b0100);
    wait_fd();
    chk("commit_ack_with_fd", bus.load_ack, 1);
    clear_seen();
    wait_fd();
    chk("d0_seg", seen_seg[0], 7'h19);
    chk("d1_seg", seen_seg[1], 7'h30);
    chk("d2_seg", seen_seg[2], 7'h24);
    chk("d3_seg", seen_seg[3], 7'h79);
    chk("d2_dp", seen_dp[2], 0);
    chk("d0_dp", seen_dp[0], 1);
    bus.blank_lz = 1'b1;
    step(3);
    base = ack_cnt;
    pulse(16'hAAAA, 4'b0000);
    step(2);
    pulse(16'h00F0, 4'b0000);
    wait_fd();
    clear_seen();
    wait_fd();
    chk("lastwin_acks", ack_cnt - base, 1);
    chk("lz_an3_dark", active[3], 0);
    chk("lz_an2_dark", active[2], 0);
    chk("lz_d1_seg", seen_seg[1], 7'h0E);
    chk("lz_d0_seg", seen_seg[0], 7'h40);
    bus.blank_lz = 1'b0;
    wait_fd();
    step(3);
    pulse(16'h1111, 4'b0000);
    step(11);
    pulse(16'h2222, 4'b0000);
    chk("bnd_ack", bus.load_ack, 1);
    chk("bnd_fd", bus.frame_done, 1);
    clear_seen();
    base = ack_cnt;
    step(16);
    chk("bnd_second_ack", ack_cnt - base, 1);
    for (int i = 0; i < N; i++) chk("bnd_show_1111", seen_seg[i], 7'h79);
    clear_seen();
    base = ack_cnt;
    step(16);
    chk("bnd_no_third_ack", ack_cnt - base, 0);
    for (int i = 0; i < N; i++) chk("bnd_show_2222", seen_seg[i], 7'h24);
    step(5);
    base = ack_cnt;
    pulse(16'hBEEF, 4'b1111);
    step(3);
    #3 rst_n = 1'b0;
    step(2);
    chk("rst_mid_an", bus.an, 4'hF);
    rst_n = 1'b1;
    clear_seen();
    wait_fd();
    chk("rst_first_fd", first_fd_n, 16);
    wait_fd();
    chk("rst_no_ack", ack_cnt - base, 0);
    for (int i = 0; i < N; i++) chk("rst_show_0000", seen_seg[i], 7'h40);
    for (int i = 0; i < N; i++) chk("rst_all_active", active[i], 1);
    bus.blank_lz = 1'b1;
    clear_seen();
    wait_fd();
    wait_fd();
    chk("zero_d0_active", active[0], 1);
    chk("zero_d0_seg", seen_seg[0], 7'h40);
    for (int i = 1; i < N; i++) chk("zero_lz_dark", active[i], 0);
    chk("zero_period", last_period, 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
